// File: rtl/dds_phase_gen_if.sv
// Bus bundle between the DDS phase generator and its controller/consumer.
//   en, clr, ftw_in, ftw_wr, poff : control and tuning inputs to the generator
//   angle, angle_valid            : folded CORDIC input angle and its strobe
//   quad_neg, sample_valid        : negate flag and strobe aligned with CORDIC output
// Modports: master drives the controls, slave is the generator itself.
interface dds_phase_gen_if #(
    parameter int unsigned ACC_W = 32
) ();
    logic                    en;
    logic                    clr;
    logic [ACC_W-1:0]        ftw_in;
    logic                    ftw_wr;
    logic signed [13:0]      poff;
    logic signed [13:0]      angle;
    logic                    angle_valid;
    logic                    quad_neg;
    logic                    sample_valid;

    modport master (
        output en, clr, ftw_in, ftw_wr, poff,
        input  angle, angle_valid, quad_neg, sample_valid
    );

    modport slave (
        input  en, clr, ftw_in, ftw_wr, poff,
        output angle, angle_valid, quad_neg, sample_valid
    );
endinterface

// File: rtl/dds_phase_gen.sv
// DDS phase generator: phase accumulator + 14-bit phase offset, folded into
// [-pi/2, pi/2) for the CORDIC stage, with the negate flag and valid strobe
// delayed by the CORDIC latency.
// Ports:
//   clk   : clock, rising edge
//   reset : asynchronous, active-high
//   bus   : dds_phase_gen_if.slave (en, clr, ftw_in, ftw_wr, poff in;
//           angle, angle_valid, quad_neg, sample_valid out)
// Parameters: ACC_W (accumulator width, >= 16), CORDIC_LAT (>= 1).
// Optional macro PHASE_DITHER_EN: adds a 16-bit LFSR dither below the phase
// truncation point.
module dds_phase_gen #(
    parameter int unsigned ACC_W      = 32,
    parameter int unsigned CORDIC_LAT = 14
) (
    input  logic            clk,
    input  logic            reset,
    dds_phase_gen_if.slave  bus
);
    localparam int unsigned PH_W   = 14;
    localparam int unsigned FRAC_W = ACC_W - PH_W;

    logic [ACC_W-1:0]      acc;
    logic [ACC_W-1:0]      ftw_act;
    logic [PH_W-1:0]       p;
    logic                  neg_c;
    logic [PH_W-1:0]       angle_c;
    logic [PH_W-1:0]       angle_q;
    logic                  neg_q;
    logic                  valid_q;
    logic [CORDIC_LAT-1:0] dly_neg;
    logic [CORDIC_LAT-1:0] dly_vld;
    logic                  advance;

    assign advance = bus.en & ~bus.clr;

    // Active tuning word; load is independent of en/clr
    always_ff @(posedge clk or posedge reset) begin
        if (reset)           ftw_act <= '0;
        else if (bus.ftw_wr) ftw_act <= bus.ftw_in;
    end

    // Phase accumulator, free wrap; clr wins over en
    always_ff @(posedge clk or posedge reset) begin
        if (reset)        acc <= '0;
        else if (bus.clr) acc <= '0;
        else if (bus.en)  acc <= acc + ftw_act;
    end

`ifdef PHASE_DITHER_EN
    logic [15:0]       lfsr;
    logic              lfsr_fb;
    logic [FRAC_W-1:0] dith;
    logic [FRAC_W:0]   frac_sum;

    // Fibonacci LFSR x^16+x^14+x^13+x^11+1 (right-shifting form)
    assign lfsr_fb = lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5];

    always_ff @(posedge clk or posedge reset) begin
        if (reset)       lfsr <= 16'hACE1;
        else if (bus.en) lfsr <= {lfsr_fb, lfsr[15:1]};
    end

    // Dither added to the discarded fraction; only its carry reaches the phase
    assign dith     = FRAC_W'(lfsr);
    assign frac_sum = {1'b0, acc[FRAC_W-1:0]} + {1'b0, dith};
    assign p        = acc[ACC_W-1 -: PH_W] + PH_W'(bus.poff) + PH_W'(frac_sum[FRAC_W]);
`else
    assign p        = acc[ACC_W-1 -: PH_W] + PH_W'(bus.poff);
`endif

    // Quadrants 1 and 2 are rotated by pi and flagged for negation
    assign neg_c   = p[13] ^ p[12];
    assign angle_c = neg_c ? {~p[13], p[12:0]} : p;

    // Folded angle register; holds while not advancing
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            angle_q <= '0;
            neg_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= advance;
            if (advance) begin
                angle_q <= angle_c;
                neg_q   <= neg_c;
            end
        end
    end

    // Free-running delay line matching the CORDIC pipeline depth
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dly_neg <= '0;
            dly_vld <= '0;
        end else begin
            dly_neg[0] <= neg_q;
            dly_vld[0] <= valid_q;
            for (int unsigned i = 1; i < CORDIC_LAT; i++) begin
                dly_neg[i] <= dly_neg[i-1];
                dly_vld[i] <= dly_vld[i-1];
            end
        end
    end

    assign bus.angle        = angle_q;
    assign bus.angle_valid  = valid_q;
    assign bus.quad_neg     = dly_neg[CORDIC_LAT-1];
    assign bus.sample_valid = dly_vld[CORDIC_LAT-1];
endmodule

// File: tb/tb_dds_phase_gen.sv
// Directed self-checking bench for dds_phase_gen (ACC_W=32, CORDIC_LAT=14).
module tb_dds_phase_gen;
    logic clk;
    logic reset;
    int   n_tests;
    int   n_fail;
    int   cnt;

    int qa[4]    = '{0, -4096, 0, -4096};
    int qn[4]    = '{0, 1, 1, 0};
    int pv[3]    = '{4095, 4096, -4097};
    int pa[3]    = '{4095, -4096, 4095};
    int pn[3]    = '{0, 1, 1};

    dds_phase_gen_if #(.ACC_W(32)) bus ();

    dds_phase_gen #(.ACC_W(32), .CORDIC_LAT(14)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, $signed(obs), $signed(exp));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_tests     = 0;
        n_fail      = 0;
        reset       = 1'b1;
        bus.en      = 1'b0;
        bus.clr     = 1'b0;
        bus.ftw_in  = '0;
        bus.ftw_wr  = 1'b0;
        bus.poff    = '0;
        #1;
        check("rst_angle", 32'(bus.angle), 0);
        check("rst_valid", 32'(bus.angle_valid), 0);
        check("rst_qneg",  32'(bus.quad_neg), 0);
        check("rst_sval",  32'(bus.sample_valid), 0);
        @(negedge clk);
        reset = 1'b0;

        // Quarter-turn sweep
        bus.en = 1'b1; bus.clr = 1'b1; bus.ftw_in = 32'h4000_0000; bus.ftw_wr = 1'b1; bus.poff = '0;
        tick();
        check("qt_clr_valid", 32'(bus.angle_valid), 0);
        bus.clr = 1'b0; bus.ftw_wr = 1'b0;
        for (int e = 2; e <= 21; e++) begin
            tick();
            check("qt_angle", 32'(bus.angle), qa[(e-2)%4]);
            check("qt_valid", 32'(bus.angle_valid), 1);
            if (e >= 16) begin
                check("qt_qneg", 32'(bus.quad_neg), qn[(e-16)%4]);
                check("qt_sval", 32'(bus.sample_valid), 1);
            end else if (e == 15) begin
                check("qt_sval_early", 32'(bus.sample_valid), 0);
            end
        end

        // Fold boundaries via phase offset, ftw = 0
        bus.clr = 1'b1; bus.ftw_wr = 1'b1; bus.ftw_in = '0;
        tick();
        bus.clr = 1'b0; bus.ftw_wr = 1'b0;
        for (int k = 0; k < 3; k++) begin
            bus.poff = 14'(pv[k]);
            tick();
            check("poff_angle", 32'(bus.angle), pa[k]);
            repeat (14) tick();
            check("poff_qneg", 32'(bus.quad_neg), pn[k]);
        end

        // Wrap-around, en=0 hold, and mid-run ftw change
        bus.poff = '0;
        bus.clr = 1'b1; bus.ftw_wr = 1'b1; bus.ftw_in = 32'hFFFC_0000;
        tick();
        bus.clr = 1'b0; bus.ftw_wr = 1'b0;
        tick();
        check("wrap_pre", 32'(bus.angle), 0);
        bus.en = 1'b0; bus.ftw_wr = 1'b1; bus.ftw_in = 32'h0004_0000;
        tick();
        check("hold_angle", 32'(bus.angle), 0);
        check("hold_valid", 32'(bus.angle_valid), 0);
        bus.en = 1'b1; bus.ftw_wr = 1'b0;
        tick();
        check("wrap_m1", 32'(bus.angle), -1);
        check("wrap_valid", 32'(bus.angle_valid), 1);
        tick();
        check("wrap_0", 32'(bus.angle), 0);
        bus.ftw_wr = 1'b1; bus.ftw_in = 32'h0008_0000;
        tick();
        check("ftw_old_1", 32'(bus.angle), 1);
        bus.ftw_wr = 1'b0;
        tick();
        check("ftw_old_2", 32'(bus.angle), 2);
        tick();
        check("ftw_new_4", 32'(bus.angle), 4);
        repeat (10) tick();
        check("wrap_qneg_m1", 32'(bus.quad_neg), 0);
        tick();
        check("wrap_qneg_0", 32'(bus.quad_neg), 0);

        // Synchronous clear mid-run
        bus.poff = 14'd100;
        bus.clr  = 1'b1;
        tick();
        check("clr_valid", 32'(bus.angle_valid), 0);
        bus.clr = 1'b0;
        tick();
        check("clr_angle", 32'(bus.angle), 100);
        check("clr_valid_back", 32'(bus.angle_valid), 1);

        // Asynchronous reset mid-run
        check("pre_rst_sval", 32'(bus.sample_valid), 1);
        #3;
        reset = 1'b1;
        #1;
        check("arst_angle", 32'(bus.angle), 0);
        check("arst_valid", 32'(bus.angle_valid), 0);
        check("arst_qneg",  32'(bus.quad_neg), 0);
        check("arst_sval",  32'(bus.sample_valid), 0);
        #1;
        reset = 1'b0;
        cnt = 0;
        for (int c = 1; c <= 40; c++) begin
            tick();
            if (bus.sample_valid === 1'b1 && cnt == 0) cnt = c;
        end
        check("arst_sval_latency", 32'(cnt), 15);

        // ftw = 2^17: one phase LSB every two samples
        bus.clr = 1'b1; bus.ftw_wr = 1'b1; bus.ftw_in = 32'h0002_0000; bus.poff = '0;
        tick();
        bus.clr = 1'b0; bus.ftw_wr = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            check("half_step", 32'(bus.angle), i / 2);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
